// File: rtl/sram_controller.sv
// sram_controller: MEM-stage responder that performs a 32-bit load/store on an
// external 16-bit asynchronous SRAM as two half-word phases (LO then HI),
// holding ready low so the pipeline freezes until the access completes.
module sram_controller #(
  parameter logic [31:0] BaseAddr = 32'd1024,  // byte address of SRAM word 0
  parameter int unsigned Wait     = 2          // cycles per half-word phase, >= 1
) (
  input  logic        clock_i,
  input  logic        reset_ni,
  input  logic        mem_r_en_i,
  input  logic        mem_w_en_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] st_value_i,
  output logic [31:0] read_data_o,
  output logic        ready_o,
  output logic [17:0] sram_addr_o,
  output logic [15:0] sram_dq_out_o,
  input  logic [15:0] sram_dq_in_i,
  output logic        sram_dq_oe_o,
  output logic        sram_we_n_o,
  output logic        sram_oe_n_o,
  output logic        sram_ce_n_o
);

  localparam int unsigned CntW = $clog2(Wait + 1);

  typedef enum logic [1:0] {StIdle, StLo, StHi, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            wr_q, wr_d;       // latched op: 1 = store, 0 = load
  logic [16:0]     idx_q, idx_d;     // latched SRAM word index
  logic [31:0]     st_q, st_d;       // latched store value
  logic [31:0]     rdata_q, rdata_d;

  logic req;
  logic last_cycle;

  assign req        = mem_r_en_i | mem_w_en_i;
  assign last_cycle = (cnt_q == CntW'(Wait - 1));

  // State register and access latches
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      st_q    <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      idx_q   <= idx_d;
      st_q    <= st_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state: accept in IDLE, count out each phase, capture read halves on the last cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    idx_d   = idx_q;
    st_d    = st_q;
    rdata_d = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          state_d = StLo;
          cnt_d   = '0;
          // Store wins when both request bits are set
          wr_d    = mem_w_en_i;
          // Wrapping subtract; byte-offset bits [1:0] drop out with the shift
          idx_d   = 17'((alu_result_i - BaseAddr) >> 2);
          st_d    = st_value_i;
        end
      end
      StLo: begin
        if (last_cycle) begin
          state_d = StHi;
          cnt_d   = '0;
          if (!wr_q) rdata_d[15:0] = sram_dq_in_i;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StHi: begin
        if (last_cycle) begin
          state_d = StDone;
          cnt_d   = '0;
          if (!wr_q) rdata_d[31:16] = sram_dq_in_i;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs: SRAM strobes only in LO/HI; address/data come from latches so they hold per phase
  always_comb begin
    logic phase;
    logic hi;
    phase         = (state_q == StLo) || (state_q == StHi);
    hi            = (state_q == StHi);
    ready_o       = ((state_q == StIdle) && !req) || (state_q == StDone);
    sram_ce_n_o   = !phase;
    sram_we_n_o   = !(phase && wr_q);
    sram_oe_n_o   = !(phase && !wr_q);
    sram_dq_oe_o  = phase && wr_q;
    sram_addr_o   = {idx_q, hi};
    sram_dq_out_o = hi ? st_q[31:16] : st_q[15:0];
    read_data_o   = rdata_q;
  end

endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller: directed checks of sram_controller against a small
// behavioural 16-bit SRAM model, with hand-computed expected values.
module tb_sram_controller;

  localparam int unsigned W = 2;
  localparam int unsigned N = 2 * W + 2;  // cycles 0 .. 2W+1 of one access

  logic        clk;
  logic        rst_n;
  logic        mem_r_en;
  logic        mem_w_en;
  logic [31:0] alu_result;
  logic [31:0] st_value;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic [15:0] sram_dq_in;
  logic        sram_dq_oe;
  logic        sram_we_n;
  logic        sram_oe_n;
  logic        sram_ce_n;

  int checks;
  int failures;

  sram_controller #(
    .BaseAddr(32'd1024),
    .Wait    (W)
  ) dut (
    .clock_i      (clk),
    .reset_ni     (rst_n),
    .mem_r_en_i   (mem_r_en),
    .mem_w_en_i   (mem_w_en),
    .alu_result_i (alu_result),
    .st_value_i   (st_value),
    .read_data_o  (read_data),
    .ready_o      (ready),
    .sram_addr_o  (sram_addr),
    .sram_dq_out_o(sram_dq_out),
    .sram_dq_in_i (sram_dq_in),
    .sram_dq_oe_o (sram_dq_oe),
    .sram_we_n_o  (sram_we_n),
    .sram_oe_n_o  (sram_oe_n),
    .sram_ce_n_o  (sram_ce_n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural asynchronous SRAM: write on the clock while strobed, read combinationally
  logic [15:0] mem [64];
  initial for (int i = 0; i < 64; i++) mem[i] = 16'hA500 + 16'(i);
  always @(posedge clk) begin
    if (!sram_ce_n && !sram_we_n) mem[sram_addr[5:0]] <= sram_dq_out;
  end
  assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[5:0]] : 16'h0000;

  // Per-access capture, index = cycle number relative to the request cycle
  logic [N-1:0] rdy_v, we_v, oe_v, ce_v, dqoe_v;
  logic [17:0]  addr_v [N];
  logic [15:0]  dout_v [N];
  logic [31:0]  rd_done;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present a request just after an edge, hold it through the freeze, drop it after DONE
  task automatic run_access(input logic r, input logic w, input logic [31:0] addr,
                            input logic [31:0] data);
    mem_r_en   = r;
    mem_w_en   = w;
    alu_result = addr;
    st_value   = data;
    for (int c = 0; c < int'(N); c++) begin
      @(negedge clk);
      rdy_v[c]  = ready;
      we_v[c]   = sram_we_n;
      oe_v[c]   = sram_oe_n;
      ce_v[c]   = sram_ce_n;
      dqoe_v[c] = sram_dq_oe;
      addr_v[c] = sram_addr;
      dout_v[c] = sram_dq_out;
      if (c == int'(N) - 1) rd_done = read_data;
      @(posedge clk);
      #1;
    end
    mem_r_en = 1'b0;
    mem_w_en = 1'b0;
  endtask

  initial begin
    int bad;
    checks     = 0;
    failures   = 0;
    rst_n      = 1'b0;
    mem_r_en   = 1'b0;
    mem_w_en   = 1'b0;
    alu_result = '0;
    st_value   = '0;

    #12;
    check_eq("rst_ready", 32'(ready), 32'd1);
    check_eq("rst_strobes", {28'd0, sram_we_n, sram_oe_n, sram_ce_n, sram_dq_oe}, 32'hE);
    check_eq("rst_read_data", read_data, 32'h0);
    check_eq("rst_addr_dout", {sram_addr[15:0], sram_dq_out}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Store 0xDEADBEEF at 1024 -> half-words 0 (BEEF) and 1 (DEAD)
    run_access(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF);
    check_eq("st_ready_seq", 32'(rdy_v), 32'h20);
    check_eq("st_we_seq", 32'(we_v), 32'h21);
    check_eq("st_ce_seq", 32'(ce_v), 32'h21);
    check_eq("st_oe_seq", 32'(oe_v), 32'h3F);
    check_eq("st_dqoe_seq", 32'(dqoe_v), 32'h1E);
    check_eq("st_lo_addr", {addr_v[2], addr_v[1][13:0]}, {18'd0, 14'd0});
    check_eq("st_hi_addr", {addr_v[4], addr_v[3][13:0]}, {18'd1, 14'd1});
    check_eq("st_lo_dout", {dout_v[1], dout_v[2]}, 32'hBEEFBEEF);
    check_eq("st_hi_dout", {dout_v[3], dout_v[4]}, 32'hDEADDEAD);
    check_eq("st_mem", {mem[1], mem[0]}, 32'hDEADBEEF);

    // Load back from 1024
    run_access(1'b1, 1'b0, 32'd1024, 32'h0);
    check_eq("ld_data", rd_done, 32'hDEADBEEF);
    check_eq("ld_dqoe_seq", 32'(dqoe_v), 32'h0);
    check_eq("ld_oe_seq", 32'(oe_v), 32'h21);
    check_eq("ld_we_seq", 32'(we_v), 32'h3F);
    check_eq("ld_ready_seq", 32'(rdy_v), 32'h20);

    // Address mapping: 1032 and 1035 both hit half-words 4/5
    run_access(1'b1, 1'b0, 32'd1032, 32'h0);
    check_eq("map1032_addr", {addr_v[1][15:0], addr_v[3][15:0]}, 32'h0004_0005);
    check_eq("map1032_data", rd_done, 32'hA505A504);
    run_access(1'b1, 1'b0, 32'd1035, 32'h0);
    check_eq("map1035_addr", {addr_v[2][15:0], addr_v[4][15:0]}, 32'h0004_0005);
    check_eq("map1035_data", rd_done, 32'hA505A504);

    // Back-to-back: store then load at 1028 starting in the cycle after DONE
    run_access(1'b0, 1'b1, 32'd1028, 32'h12345678);
    check_eq("b2b_st_ready_seq", 32'(rdy_v), 32'h20);
    run_access(1'b1, 1'b0, 32'd1028, 32'h0);
    check_eq("b2b_ld_ready_seq", 32'(rdy_v), 32'h20);
    check_eq("b2b_ld_addr", {addr_v[1][15:0], addr_v[3][15:0]}, 32'h0002_0003);
    check_eq("b2b_ld_data", rd_done, 32'h12345678);

    // Both request bits: store wins, read_data unchanged
    run_access(1'b1, 1'b1, 32'd1040, 32'hCAFEF00D);
    check_eq("both_we_seq", 32'(we_v), 32'h21);
    check_eq("both_read_data", rd_done, 32'h12345678);
    check_eq("both_mem", {mem[9], mem[8]}, 32'hCAFEF00D);
    run_access(1'b1, 1'b0, 32'd1040, 32'h0);
    check_eq("both_readback", rd_done, 32'hCAFEF00D);

    // Idle: ready high, strobes inactive
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ready !== 1'b1 || sram_we_n !== 1'b1 || sram_oe_n !== 1'b1 ||
          sram_ce_n !== 1'b1 || sram_dq_oe !== 1'b0) bad++;
    end
    check_eq("idle_bad_cycles", 32'(bad), 32'd0);
    @(posedge clk);
    #1;

    // Reset during HI of a store at 1044 (half-words 10/11)
    mem_w_en   = 1'b1;
    alu_result = 32'd1044;
    st_value   = 32'h55AA33CC;
    repeat (W + 1) @(posedge clk);
    #1;
    check_eq("mid_hi_addr_ce", {sram_addr[15:0], 15'd0, sram_ce_n}, {16'd11, 16'd0});
    mem_w_en = 1'b0;
    rst_n    = 1'b0;
    #1;
    check_eq("mid_rst_strobes", {28'd0, sram_we_n, sram_oe_n, sram_ce_n, sram_dq_oe}, 32'hE);
    check_eq("mid_rst_read_data", read_data, 32'h0);
    check_eq("mid_rst_ready", 32'(ready), 32'd1);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("post_rst_idle", {30'd0, ready, sram_ce_n}, 32'h3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
